// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the write-back stage.
//   wb_kind_e  : where the written value comes from
//   ld_size_e  : load access size
//   wb_state_e : write-back FSM state
//   size_bits  : bit width of a load size
package wb_pkg;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_LUI  = 2'd2,
    KIND_LINK = 2'd3
  } wb_kind_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } ld_size_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_LD = 1'b1
  } wb_state_e;

  function automatic logic [6:0] size_bits(input ld_size_e size);
    logic [6:0] bits;
    case (size)
      SIZE_B:  bits = 7'd8;
      SIZE_H:  bits = 7'd16;
      SIZE_W:  bits = 7'd32;
      default: bits = 7'd64;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load lane select and extension.
// Ports:
//   i_rdata    [XLEN] raw memory return word
//   i_size            load size (B/H/W/D)
//   i_unsigned        1 = zero-extend, 0 = sign-extend
//   i_addr_lo  [3]    low address bits (only [1:0] when XLEN=32)
//   o_data     [XLEN] extracted, extended value
//   o_misalign        access not naturally aligned, or D on a 32-bit datapath
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  ld_size_e        i_size,
  input  logic            i_unsigned,
  input  logic [2:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [2:0]      w_off;
  logic [6:0]      w_width;
  logic [6:0]      w_pad;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_left;

  // The lane is moved down to bit 0, then pushed to the top and shifted back
  // down so the extension needs no size-dependent replication.
  always_comb begin
    w_off   = (XLEN == 64) ? i_addr_lo : {1'b0, i_addr_lo[1:0]};
    w_lane  = i_rdata >> {w_off, 3'b000};
    // D on a 32-bit datapath is flagged misaligned; clamp so the shift stays sane.
    w_width = (size_bits(i_size) > 7'(XLEN)) ? 7'(XLEN) : size_bits(i_size);
    w_pad   = 7'(XLEN) - w_width;
    w_left  = w_lane << w_pad;
    o_data  = '0;
    if (i_unsigned) begin
      o_data = w_left >> w_pad;
    end else begin
      o_data = $signed(w_left) >>> w_pad;
    end
  end

  always_comb begin
    o_misalign = 1'b0;
    case (i_size)
      SIZE_B:  o_misalign = 1'b0;
      SIZE_H:  o_misalign = w_off[0];
      SIZE_W:  o_misalign = (w_off[1:0] != 2'b00);
      default: o_misalign = (XLEN != 64) || (w_off != 3'b000);
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Accepts one instruction bundle at a time,
// produces a registered register-file write, and waits for load data on loads.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | in_ready=1, bundles accepted; non-load writes issue next cycle
// ST_WAIT_LD | load latched, waiting for mem_rvalid; in_ready=0
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           bundle handshake
//   in_kind                     result source (ALU/LOAD/LUI/LINK)
//   in_alures, in_imm, in_pc4   candidate write values
//   in_size, in_unsigned,
//   in_addr_lo                  load shape
//   in_rd, in_we                destination and write intent
//   mem_rvalid, mem_rdata       load data return
//   rf_we, rf_waddr, rf_wdata   register-file write port (registered)
//   err_misalign                one-cycle pulse on a misaligned load
//   err_spurious                sticky: mem_rvalid seen while idle
//   retire_cnt                  completed bundle count (wraps)
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [XLEN-1:0] in_alures,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [2:0]      in_addr_lo,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_we,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err_misalign,
  output logic            err_spurious,
  output logic [31:0]     retire_cnt
);

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;

  ld_size_e        r_ld_size;
  logic            r_ld_unsigned;
  logic [2:0]      r_ld_addr_lo;
  logic [RAW-1:0]  r_ld_rd;
  logic            r_ld_we;

  logic            r_rf_we;
  logic [RAW-1:0]  r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_err_misalign;
  logic            r_err_spurious;
  logic [31:0]     r_retire_cnt;

  logic            w_latch_ld;
  logic            w_complete;
  logic            w_wr_en;
  logic [RAW-1:0]  w_wr_addr;
  logic [XLEN-1:0] w_wr_data;
  logic            w_misalign;
  logic            w_spurious;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_misalign;

  wb_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_rdata   (mem_rdata),
    .i_size    (r_ld_size),
    .i_unsigned(r_ld_unsigned),
    .i_addr_lo (r_ld_addr_lo),
    .o_data    (w_ld_data),
    .o_misalign(w_ld_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_ld  = 1'b0;
    w_complete  = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = in_rd;
    w_wr_data   = in_alures;
    w_misalign  = 1'b0;
    w_spurious  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // mem_rvalid has no owner here; it only raises the sticky error.
        w_spurious = mem_rvalid;
        if (in_valid) begin
          if (wb_kind_e'(in_kind) == KIND_LOAD) begin
            w_latch_ld  = 1'b1;
            w_state_nxt = ST_WAIT_LD;
          end else begin
            w_complete = 1'b1;
            w_wr_en    = in_we && (in_rd != '0);
            case (wb_kind_e'(in_kind))
              KIND_LUI:  w_wr_data = in_imm;
              KIND_LINK: w_wr_data = in_pc4;
              default:   w_wr_data = in_alures;
            endcase
          end
        end
      end
      ST_WAIT_LD: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_IDLE;
          w_complete  = 1'b1;
          w_wr_addr   = r_ld_rd;
          w_wr_data   = w_ld_data;
          w_misalign  = w_ld_misalign;
          w_wr_en     = r_ld_we && (r_ld_rd != '0) && !w_ld_misalign;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_size      <= SIZE_B;
      r_ld_unsigned  <= 1'b0;
      r_ld_addr_lo   <= 3'b000;
      r_ld_rd        <= '0;
      r_ld_we        <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_err_misalign <= 1'b0;
      r_err_spurious <= 1'b0;
      r_retire_cnt   <= 32'd0;
    end else begin
      r_rf_we        <= w_wr_en;
      r_err_misalign <= w_misalign;
      if (w_latch_ld) begin
        r_ld_size     <= ld_size_e'(in_size);
        r_ld_unsigned <= in_unsigned;
        r_ld_addr_lo  <= in_addr_lo;
        r_ld_rd       <= in_rd;
        r_ld_we       <= in_we;
      end
      if (w_complete) begin
        r_rf_waddr   <= w_wr_addr;
        r_rf_wdata   <= w_wr_data;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (w_spurious) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign err_misalign = r_err_misalign;
  assign err_spurious = r_err_spurious;
  assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int XLEN = 32;
  localparam int RAW  = 5;

  localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_LUI = 2'd2, K_LINK = 2'd3;
  localparam logic [1:0] S_B = 2'd0, S_H = 2'd1, S_W = 2'd2, S_D = 2'd3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_kind = '0;
  logic [XLEN-1:0] in_alures = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic [XLEN-1:0] in_pc4 = '0;
  logic [1:0]      in_size = '0;
  logic            in_unsigned = 1'b0;
  logic [2:0]      in_addr_lo = '0;
  logic [RAW-1:0]  in_rd = '0;
  logic            in_we = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            rf_we;
  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            err_misalign;
  logic            err_spurious;
  logic [31:0]     retire_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_alures(in_alures), .in_imm(in_imm), .in_pc4(in_pc4),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr_lo(in_addr_lo),
    .in_rd(in_rd), .in_we(in_we),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_misalign(err_misalign), .err_spurious(err_spurious),
    .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          mis_pulses = 0;
  logic [31:0] exp_retire = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_misalign) mis_pulses++;
      if (rf_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rf_waddr, rf_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (rf_waddr !== mon_e.addr || rf_wdata !== mon_e.data) begin
            errors++;
            $display("FAIL write_data: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                     rf_waddr, rf_wdata, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [RAW-1:0] rd, input logic we,
                       input logic [XLEN-1:0] val, input logic [1:0] size,
                       input logic uns, input logic [2:0] lo);
    int n;
    n = 0;
    in_kind = kind; in_rd = rd; in_we = we;
    in_alures = val; in_imm = val ^ 32'h0F0F_0F0F; in_pc4 = val ^ 32'hF0F0_F0F0;
    if (kind == K_LUI) in_imm = val;
    if (kind == K_LINK) in_pc4 = val;
    in_size = size; in_unsigned = uns; in_addr_lo = lo;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic mem_return(input int delay, input logic [XLEN-1:0] data);
    for (int i = 0; i < delay; i++) begin
      check("in_ready_wait", in_ready, 0);
      if (i == delay - 1) begin
        mem_rdata  = data;
        mem_rvalid = 1'b1;
      end else begin
        tick();
      end
    end
    tick();
    mem_rvalid = 1'b0;
    check("in_ready_after_load", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_waddr", rf_waddr, 0);
    check("reset_rf_wdata", rf_wdata, 0);
    check("reset_err_misalign", err_misalign, 0);
    check("reset_err_spurious", err_spurious, 0);
    check("reset_retire", retire_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("ready_after_reset", in_ready, 1);

    // Back-to-back ALU writes
    exp_q.push_back('{addr: 5'd5, data: 32'h1111_0005});
    issue(K_ALU, 5'd5, 1'b1, 32'h1111_0005, S_B, 1'b0, 3'd0);
    exp_retire++;
    check("b2b_first_we", rf_we, 1);
    check("b2b_first_addr", rf_waddr, 5);
    exp_q.push_back('{addr: 5'd6, data: 32'h2222_0006});
    issue(K_ALU, 5'd6, 1'b1, 32'h2222_0006, S_B, 1'b0, 3'd0);
    exp_retire++;
    check("b2b_second_we", rf_we, 1);
    check("b2b_second_addr", rf_waddr, 6);
    check("b2b_retire", retire_cnt, 32'd2);
    tick();
    check("b2b_we_drops", rf_we, 0);

    // LOAD B signed, lane 3, data 3 cycles after accept
    exp_q.push_back('{addr: 5'd1, data: 32'hFFFF_FF80});
    issue(K_LOAD, 5'd1, 1'b1, '0, S_B, 1'b0, 3'd3);
    mem_return(3, 32'h80FF_FF12);
    exp_retire++;
    check("ldb_we", rf_we, 1);
    check("ldb_data", rf_wdata, 32'hFFFF_FF80);
    check("ldb_retire", retire_cnt, exp_retire);

    // LOAD H unsigned, upper half
    exp_q.push_back('{addr: 5'd7, data: 32'h0000_8001});
    issue(K_LOAD, 5'd7, 1'b1, '0, S_H, 1'b1, 3'd2);
    mem_return(1, 32'h8001_1234);
    exp_retire++;
    check("ldh_data", rf_wdata, 32'h0000_8001);

    // LOAD H misaligned
    issue(K_LOAD, 5'd8, 1'b1, '0, S_H, 1'b1, 3'd1);
    mem_return(2, 32'h8001_1234);
    exp_retire++;
    check("mis_h_we", rf_we, 0);
    check("mis_h_pulse", err_misalign, 1);
    check("mis_h_retire", retire_cnt, exp_retire);
    tick();
    check("mis_h_pulse_end", err_misalign, 0);

    // More load shapes and sources
    exp_q.push_back('{addr: 5'd9, data: 32'h8000_0001});
    issue(K_LOAD, 5'd9, 1'b1, '0, S_W, 1'b0, 3'd0);
    mem_return(1, 32'h8000_0001);
    exp_retire++;
    exp_q.push_back('{addr: 5'd10, data: 32'h0000_00AB});
    issue(K_LOAD, 5'd10, 1'b1, '0, S_B, 1'b1, 3'd1);
    mem_return(2, 32'h0000_AB00);
    exp_retire++;
    exp_q.push_back('{addr: 5'd11, data: 32'hFFFF_8001});
    issue(K_LOAD, 5'd11, 1'b1, '0, S_H, 1'b0, 3'd2);
    mem_return(1, 32'h8001_1234);
    exp_retire++;
    exp_q.push_back('{addr: 5'd12, data: 32'h1234_5000});
    issue(K_LUI, 5'd12, 1'b1, 32'h1234_5000, S_B, 1'b0, 3'd0);
    exp_retire++;
    issue(K_LOAD, 5'd2, 1'b1, '0, S_D, 1'b0, 3'd0);
    mem_return(1, 32'h5555_AAAA);
    exp_retire++;
    check("mis_d_we", rf_we, 0);
    check("mis_d_pulse", err_misalign, 1);
    check("shapes_retire", retire_cnt, exp_retire);

    // Suppressed writes still retire
    issue(K_LINK, 5'd0, 1'b1, 32'h0000_0104, S_B, 1'b0, 3'd0);
    exp_retire++;
    check("link_rd0_we", rf_we, 0);
    check("link_rd0_retire", retire_cnt, exp_retire);
    issue(K_ALU, 5'd3, 1'b0, 32'h3333_3333, S_B, 1'b0, 3'd0);
    exp_retire++;
    check("no_we_we", rf_we, 0);
    exp_q.push_back('{addr: 5'd13, data: 32'h0000_0104});
    issue(K_LINK, 5'd13, 1'b1, 32'h0000_0104, S_B, 1'b0, 3'd0);
    exp_retire++;
    check("link_retire", retire_cnt, exp_retire);

    // Spurious return while idle
    check("spur_before", err_spurious, 0);
    mem_rdata = 32'h7777_7777;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("spur_set", err_spurious, 1);
    check("spur_no_write", rf_we, 0);
    tick(); tick(); tick();
    check("spur_sticky", err_spurious, 1);
    check("spur_retire", retire_cnt, exp_retire);

    // Reset while waiting on a load
    issue(K_LOAD, 5'd14, 1'b1, '0, S_W, 1'b0, 3'd0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_retire = '0;
    check("rst_wait_we", rf_we, 0);
    check("rst_wait_waddr", rf_waddr, 0);
    check("rst_wait_wdata", rf_wdata, 0);
    check("rst_wait_spur", err_spurious, 0);
    check("rst_wait_retire", retire_cnt, 0);
    check("rst_wait_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    mem_rdata = 32'h1234_5678;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("late_rvalid_spur", err_spurious, 1);
    check("late_rvalid_we", rf_we, 0);
    check("late_rvalid_retire", retire_cnt, 0);

    // Retire counter wrap
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retire_cnt;
    check("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
    exp_q.push_back('{addr: 5'd15, data: 32'hDEAD_BEEF});
    issue(K_ALU, 5'd15, 1'b1, 32'hDEAD_BEEF, S_B, 1'b0, 3'd0);
    check("wrap_retire", retire_cnt, 0);

    tick(); tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    check("misalign_pulses", mis_pulses, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
